// File: rtl/rr_enc_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index
// and an optional hold limit that forces release so no requester starves.
module rr_enc_arbiter_4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               LIMIT_EN  = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [3:0]       gnt_q;
  logic [1:0]       idx_q;
  logic             preempt_q;

  logic             win_any;
  logic [1:0]       win_idx;

  // First set request scanning upward from ptr_q, wrapping mod 4.
  always_comb begin
    win_any = 1'b0;
    win_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cand;
      cand = ptr_q + 2'(i);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      idx_q      <= 2'd0;
      preempt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          preempt_q  <= 1'b0;
          hold_cnt_q <= '0;
          if (win_any) begin
            gnt_q   <= 4'b0001 << win_idx;
            idx_q   <= win_idx;
            state_q <= GRANT;
          end else begin
            gnt_q <= 4'b0000;
            idx_q <= 2'd0;
          end
        end
        GRANT: begin
          // A dropped request wins over an expiring limit: no preempt then.
          if (!req[idx_q] || (LIMIT_EN && hold_cnt_q == HOLD_LAST)) begin
            preempt_q <= req[idx_q];
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            ptr_q     <= idx_q + 2'd1;
            state_q   <= IDLE;
          end else begin
            preempt_q <= 1'b0;
            if (hold_cnt_q != CNT_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_q     <= 4'b0000;
          idx_q     <= 2'd0;
          preempt_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_enc_arbiter_4.sv
// Directed bench: a vector table drives a HOLD_MAX=4 arbiter, a hand-written
// sequence drives a HOLD_MAX=0 arbiter to check the unlimited hold case.
module tb_rr_enc_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4, req0;
  logic [3:0] gnt4, gnt0;
  logic [1:0] idx4, idx0;
  logic       val4, val0;
  logic       pre4, pre0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_enc_arbiter_4 #(.HOLD_MAX(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .preempt(pre4)
  );

  rr_enc_arbiter_4 #(.HOLD_MAX(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .preempt(pre0)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] rq, logic [3:0] g, logic [1:0] ix, logic p);
    vec_t v;
    v.rst = r;
    v.req = rq;
    v.gnt = g;
    v.idx = ix;
    v.pre = p;
    vecs.push_back(v);
  endfunction

  function automatic void add_hold(logic [3:0] rq, int k, int n);
    for (int i = 0; i < n; i++) add(1'b0, rq, 4'(1 << k), 2'(k), 1'b0);
  endfunction

  task automatic check(string name, int step, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, step, act, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req4 = 4'b0000;
    req0 = 4'b0000;

    // Reset and quiet idle.
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // Single requester 2, normal release moves ptr to 3.
    add_hold(4'b0100, 2, 3);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // All requesting: rotation from 3, each grant preempted after 4 cycles.
    add_hold(4'b1111, 3, 4);
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add_hold(4'b1111, k, 4);
      add(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1);
    end
    add_hold(4'b1111, 0, 1);
    // Reset overrides the grant; then 0011 with early release of requester 0.
    add(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0);
    add_hold(4'b0011, 0, 2);
    add(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0);
    add_hold(4'b0010, 1, 4);
    add(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b1);
    // Release coinciding with limit expiry is a normal release.
    add_hold(4'b0010, 1, 4);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // Reset during a grant to requester 3, then ptr restarts at 0.
    add_hold(4'b1000, 3, 2);
    add(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0);
    add_hold(4'b1000, 3, 1);
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    add_hold(4'b1111, 0, 1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    foreach (vecs[s]) begin
      rst  = vecs[s].rst;
      req4 = vecs[s].req;
      @(posedge clk);
      #1;
      check("gnt",       s, {4'b0, gnt4}, {4'b0, vecs[s].gnt});
      check("gnt_idx",   s, {6'b0, idx4}, {6'b0, vecs[s].idx});
      check("gnt_valid", s, {7'b0, val4}, {7'b0, (vecs[s].gnt != 4'b0000)});
      check("preempt",   s, {7'b0, pre4}, {7'b0, vecs[s].pre});
    end

    // Unlimited hold: grant never drops and the counter saturates.
    rst  = 1'b0;
    req4 = 4'b0000;
    req0 = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      check("nolimit_gnt",     c, {4'b0, gnt0}, 8'h01);
      check("nolimit_valid",   c, {7'b0, val0}, 8'h01);
      check("nolimit_preempt", c, {7'b0, pre0}, 8'h00);
    end
    check("nolimit_hold_cnt", 300, u_dut0.hold_cnt_q, 8'd255);
    req0 = 4'b0000;
    @(posedge clk);
    #1;
    check("nolimit_release_gnt", 301, {4'b0, gnt0}, 8'h00);
    check("nolimit_release_pre", 301, {7'b0, pre0}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_enc_arbiter_4.md
Name: rr_enc_arbiter_4

Overview:
Round-robin arbiter that shares one downstream resource among four requesters. It issues a registered one-hot grant and the matching 2-bit encoded index (0001->0, 0010->1, 0100->2, 1000->3) to the shared datapath. Priority rotates and an optional hold limit forces release, so no requester can be starved.

Parameters:
HOLD_MAX, 8, maximum consecutive grant cycles per requester; 0 disables the limit (grant held until the request drops).
CNT_W, 8, width of the hold counter; HOLD_MAX must be < 2**CNT_W.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  4  request vector; bit n = requester n; level-sensitive.
gnt  output 4  one-hot grant, registered; 0000 when nothing is granted.
gnt_idx  output 2  binary index of the set gnt bit; 2'b00 when gnt_valid=0.
gnt_valid  output 1  high while any grant is active (equals |gnt).
preempt  output 1  one-cycle pulse marking a grant forcibly ended by HOLD_MAX.

Behaviour:
- Reset: already decided, one clock, reset is synchronous and active-high (clk, rst). On rst=1 at an edge: gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides everything, including an active grant: gnt drops at the next edge with no preempt pulse.
- State: ptr (2 bits) holds the highest-priority requester. FSM has two states, IDLE and GRANT.
- IDLE: if req != 0 at an edge, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). At that edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=GRANT. Latency from req sampled to gnt visible is 1 cycle. If req=0000, stay in IDLE with outputs at 0.
- GRANT: evaluated at each edge, in priority order:
  - req[gnt_idx]=0 (normal release): gnt=0000, gnt_idx=00, gnt_valid=0, ptr=gnt_idx+1 mod 4, state=IDLE, preempt=0.
  - HOLD_MAX!=0 and hold_cnt=HOLD_MAX-1 (forced release): same outputs as normal release, plus preempt=1 for exactly that one cycle.
  - Otherwise: hold the grant and increment hold_cnt. The counter saturates and does not wrap when HOLD_MAX=0.
- The grant is held for exactly HOLD_MAX cycles when the limit is hit. Every release is followed by exactly one IDLE cycle with gnt=0000 before the next grant. Re-arbitration then uses the updated ptr, so the just-released requester has lowest priority.
- Changes on req bits other than the granted one never disturb an active grant.
- Simultaneous release and limit expiry in the same cycle: treated as a normal release, preempt=0.
- preempt is 0 in every cycle other than the forced-release cycle.
- Invariants: gnt is always zero or one-hot; gnt_valid==|gnt; when gnt_valid=1, gnt_idx is the encoder of gnt; when gnt_valid=0, gnt_idx=00.
- All outputs are registered; there is no combinational path from req to any output.

Test Plan:
- rst high for 2 cycles, then req=0000 for 5 cycles -> gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0 throughout.
- After reset, req=0100 held; then drop req[2] at cycle 6 -> gnt=0100, gnt_idx=2, gnt_valid=1 one cycle after req is applied; gnt drops at the next edge after req[2]=0; ptr becomes 3.
- HOLD_MAX=4, req=1111 held continuously from reset -> grant sequence 0,1,2,3,0. Each grant lasts 4 cycles, preempt pulses on each drop cycle, and one gnt=0000 cycle separates grants.
- HOLD_MAX=4, req=0011; release req[0] after 2 grant cycles -> requester 1 is granted after the one idle cycle, preempt=0; requester 1 is later preempted after 4 cycles.
- Active grant to requester 3, assert rst for one cycle -> gnt=0000 and preempt=0 at the next edge; after rst deasserts with req=1000, requester 3 is granted again with ptr restarted at 0.
- HOLD_MAX=0, req=0001 held for 300 cycles -> grant never drops, preempt never asserts, hold_cnt saturates at 255 without wrapping.
